mem_access_ctrl: RTL

// Request/response controller upstream of the 4Kx16 main memory. Accepts CPU memory ops
// (read, write, increment-and-store for ISZ) over a valid/ready handshake and sequences
// the RAM's addr/data_in/wr_en/rd_en. Samples the RAM's asynchronous read data into a

---
 rtl/mem_access_ctrl_if.sv | 26 ++
 rtl/mem_access_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - CPU-side request/response bundle for mem_access_ctrl
interface mem_access_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_zero;
  logic                  rsp_err;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_zero, rsp_err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - sequences READ/WRITE/INC ops onto the 4Kx16 main RAM
// Moore FSM; the RAM read data is captured into rdata_q on the ACCESS edge.
module mem_access_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_access_ctrl_if.slave      bus,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_INC    = 2'b10;
  localparam logic [1:0] OP_ILL    = 2'b11;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_WRBACK, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [1:0]            op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [3:0]            wait_cnt_q;
  logic                  zero_q;
  logic                  err_q;
  logic                  accept;
  logic [DATA_WIDTH-1:0] access_data;

  assign bus.req_ready = (state_q == S_IDLE) & rst_n;
  assign accept        = bus.req_valid & bus.req_ready;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_zero  = zero_q;
  assign bus.rsp_err   = err_q;
  assign mem_addr      = addr_q;

  always_comb begin
    state_d     = state_q;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wdata   = wdata_q;
    access_data = mem_rdata;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.req_op == OP_ILL)    state_d = S_RESP;
          else if (WAIT_INIT != 4'd0)  state_d = S_WAIT;
          else                         state_d = S_ACCESS;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == 4'd1) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (op_q == OP_WRITE) begin
          mem_wr_en   = 1'b1;
          access_data = wdata_q;
          state_d     = S_RESP;
        end else if (op_q == OP_INC) begin
          mem_rd_en   = 1'b1;
          access_data = mem_rdata + DATA_WIDTH'(1);
          state_d     = S_WRBACK;
        end else begin
          mem_rd_en   = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_WRBACK: begin
        // INC write-back uses the incremented value already held in rdata_q
        mem_wr_en = 1'b1;
        mem_wdata = rdata_q;
        state_d   = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      wait_cnt_q <= 4'd0;
      zero_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        op_q       <= bus.req_op;
        addr_q     <= bus.req_addr;
        wdata_q    <= bus.req_wdata;
        err_q      <= (bus.req_op == OP_ILL);
        wait_cnt_q <= WAIT_INIT;
      end
      if (state_q == S_WAIT) wait_cnt_q <= wait_cnt_q - 4'd1;
      if (state_q == S_ACCESS) begin
        rdata_q <= access_data;
        zero_q  <= (access_data == '0);
      end
    end
  end

endmodule
